// File: rtl/afe_cal_pkg.sv
// Shared constants and helpers for the AFE calibration twin.
// Holds capacitor phase codes, sample widths, saturation value and LFSR setup.
// No logic of its own; imported by the sampler and the top.
package afe_cal_pkg;

  localparam int SAMPLE_W = 20;
  localparam int ITOT_W   = 11;

  typedef enum logic [1:0] {
    C_OPEN    = 2'd0,
    C_SHARE   = 2'd1,
    C_SAMPLE  = 2'd2,
    C_ILLEGAL = 2'd3
  } phase_e;

  // Open diode stack reads as a rail-high sample.
  localparam logic [SAMPLE_W-1:0] SAT = 20'hFFFFF;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // More parallel diodes -> lower current density -> smaller voltage swing.
  function automatic logic [1:0] stack_shift(input logic [3:0] n);
    if (n <= 4'd1)      return 2'd0;
    else if (n == 4'd2) return 2'd1;
    else if (n <= 4'd4) return 2'd2;
    else                return 2'd3;
  endfunction

endpackage

// File: rtl/afe_cal_model_if.sv
// Calibration bus between the bias controller (master) and the AFE twin (slave).
// Signals: res_n, diode, ib, ibf, c1, c2, idac_o driven by the controller; cmp_o returned.
// No handshake: the controller owns timing, the AFE answers with fixed latency.
interface afe_cal_model_if;
  logic       res_n;
  logic [7:0] diode;
  logic [7:0] ib;
  logic [7:0] ibf;
  logic [1:0] c1;
  logic [1:0] c2;
  logic [3:0] idac_o;
  logic       cmp_o;

  modport master (output res_n, diode, ib, ibf, c1, c2, idac_o, input cmp_o);
  modport slave  (input res_n, diode, ib, ibf, c1, c2, idac_o, output cmp_o);
endinterface

// File: rtl/afe_cal_sampler.sv
// Diode sample computation plus s1/s2 capture registers and pending-evaluation flag.
// Latency: captures land on the clock edge where the phase code is presented.
// Backpressure: none; eval_fire is held off while s2 keeps being re-captured.
// Ports: clk/reset, bus inputs (res_n, diode, ib, ibf, c1, c2), eval_fire, s1_o, s2_o.
module afe_cal_sampler
  import afe_cal_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] VBE0       = 20'd40000,
  parameter logic [7:0]          DIODE_GAIN = 8'd4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                res_n,
  input  logic [7:0]          diode,
  input  logic [7:0]          ib,
  input  logic [7:0]          ibf,
  input  logic [1:0]          c1,
  input  logic [1:0]          c2,
  output logic                eval_fire,
  output logic [SAMPLE_W-1:0] s1_o,
  output logic [SAMPLE_W-1:0] s2_o
);

  logic [ITOT_W-1:0]   itot;
  logic [3:0]          n;
  logic [1:0]          sh;
  logic [SAMPLE_W-1:0] scaled;
  logic [SAMPLE_W-1:0] sample;
  logic                cap1;
  logic                cap2;
  logic                eval_pend;

  assign itot   = {1'b0, ib, 2'b00} + {3'b000, ibf};
  assign n      = popcount8(diode);
  assign sh     = stack_shift(n);
  assign scaled = (SAMPLE_W'(itot) * SAMPLE_W'(DIODE_GAIN)) >> sh;
  assign sample = (n == 4'd0) ? SAT : VBE0 + scaled;

  // Both caps sampling at once is a collision: neither capture happens.
  assign cap1 = (c1 == C_SAMPLE) && (c2 != C_SAMPLE) && res_n;
  assign cap2 = (c2 == C_SAMPLE) && (c1 != C_SAMPLE);

  // A fresh s2 capture defers evaluation so the newest sample is compared once.
  assign eval_fire = eval_pend && !cap2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_o      <= VBE0;
      s2_o      <= VBE0;
      eval_pend <= 1'b0;
    end else begin
      if (cap1) s1_o <= sample;
      if (cap2) begin
        s2_o      <= sample;
        eval_pend <= 1'b1;
      end else if (eval_fire) begin
        eval_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/afe_cal_model.sv
// Digital twin of the diode/comparator front end answering the bias calibration loop.
// Latency: s2 capture at edge E, evaluation at E+1, cmp_o updated at E+1+CMP_DELAY.
// Backpressure: none; cmp_o holds between evaluations, proto_err is sticky until reset.
// Ports: clk, reset, bus (afe_cal_model_if.slave), s1_o, s2_o, eval_cnt, proto_err.
// Optional: define AFE_CAL_NOISE_EN to add LFSR dither (-16..+15) to delta before compare.
module afe_cal_model
  import afe_cal_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] VBE0       = 20'd40000,
  parameter logic [7:0]          DIODE_GAIN = 8'd4,
  parameter logic [SAMPLE_W-1:0] TARGET     = 20'd1000,
  parameter logic [SAMPLE_W-1:0] IDAC_STEP  = 20'd64,
  parameter int                  CMP_DELAY  = 1
) (
  input  logic                clk,
  input  logic                reset,
  afe_cal_model_if.slave      bus,
  output logic [SAMPLE_W-1:0] s1_o,
  output logic [SAMPLE_W-1:0] s2_o,
  output logic [15:0]         eval_cnt,
  output logic                proto_err
);

  logic                 eval_fire;
  logic signed [21:0]   delta;
  logic signed [21:0]   thr;
  logic                 result;
  logic                 proto_viol;
  logic                 cmp_q;
  logic [CMP_DELAY-1:0] pipe_vld;
  logic [CMP_DELAY-1:0] pipe_val;

  afe_cal_sampler #(
    .VBE0       (VBE0),
    .DIODE_GAIN (DIODE_GAIN)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .res_n     (bus.res_n),
    .diode     (bus.diode),
    .ib        (bus.ib),
    .ibf       (bus.ibf),
    .c1        (bus.c1),
    .c2        (bus.c2),
    .eval_fire (eval_fire),
    .s1_o      (s1_o),
    .s2_o      (s2_o)
  );

  // Two guard bits: 21-bit signed delta plus headroom for dither.
  assign delta = $signed({2'b00, s1_o}) - $signed({2'b00, s2_o});
  assign thr   = $signed({2'b00, TARGET + SAMPLE_W'(bus.idac_o) * IDAC_STEP});

`ifdef AFE_CAL_NOISE_EN
  logic [15:0]        lfsr;
  logic signed [21:0] noise;

  assign noise  = $signed({17'd0, lfsr[4:0]}) - 22'sd16;
  assign result = (delta + noise) > thr;

  always_ff @(posedge clk) begin
    if (reset)          lfsr <= LFSR_SEED;
    else if (eval_fire) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end
`else
  assign result = delta > thr;
`endif

  assign proto_viol = (bus.c1 == C_ILLEGAL) || (bus.c2 == C_ILLEGAL) ||
                      ((bus.c1 == C_SAMPLE) && (bus.c2 == C_SAMPLE));

  assign bus.cmp_o = cmp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld  <= '0;
      pipe_val  <= '0;
      cmp_q     <= 1'b0;
      eval_cnt  <= 16'd0;
      proto_err <= 1'b0;
    end else begin
      pipe_vld[0] <= eval_fire;
      pipe_val[0] <= result;
      for (int i = 1; i < CMP_DELAY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_val[i] <= pipe_val[i-1];
      end
      // Only a valid slot updates cmp_o, so the result holds between evaluations.
      if (pipe_vld[CMP_DELAY-1]) cmp_q <= pipe_val[CMP_DELAY-1];
      if (eval_fire)  eval_cnt  <= eval_cnt + 16'd1;
      if (proto_viol) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_afe_cal_model.sv
// Directed bench for afe_cal_model: hand-computed samples, compare results and counters.
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_afe_cal_model;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] s1_o;
  logic [19:0] s2_o;
  logic [15:0] eval_cnt;
  logic        proto_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  afe_cal_model_if bus();

  afe_cal_model u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .s1_o      (s1_o),
    .s2_o      (s2_o),
    .eval_cnt  (eval_cnt),
    .proto_err (proto_err)
  );

  always #50 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // s1 capture with one diode, then s2 capture with eight; returns just after the eval edge.
  task automatic run_seq(input logic [7:0] ib_v, input logic [7:0] ibf_v, input logic [3:0] idac_v);
    bus.ib = ib_v; bus.ibf = ibf_v; bus.idac_o = idac_v; bus.res_n = 1'b1;
    bus.diode = 8'h01; bus.c1 = 2'd2; bus.c2 = 2'd0;
    step();
    bus.diode = 8'hFF; bus.c1 = 2'd0; bus.c2 = 2'd2;
    step();
    bus.c2 = 2'd0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus.res_n = 1'b1; bus.diode = 8'h00; bus.ib = 8'd0; bus.ibf = 8'd0;
    bus.c1 = 2'd0; bus.c2 = 2'd0; bus.idac_o = 4'd0;
    step(); step();
    reset = 1'b0;
    step();

    chk("rst_cmp", 32'(bus.cmp_o), 32'd0);
    chk("rst_s1", 32'(s1_o), 32'd40000);
    chk("rst_s2", 32'(s2_o), 32'd40000);
    chk("rst_cnt", 32'(eval_cnt), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);

    // itot=571: s1 = 40000+2284, s2 = 40000+285, delta 1999 > 1000
    run_seq(8'd127, 8'd63, 4'd0);
    chk("t1_cmp_early", 32'(bus.cmp_o), 32'd0);
    chk("t1_cnt", 32'(eval_cnt), 32'd1);
    step();
    chk("t1_s1", 32'(s1_o), 32'd42284);
    chk("t1_s2", 32'(s2_o), 32'd40285);
    chk("t1_cmp", 32'(bus.cmp_o), 32'd1);

    // itot=200: offsets 800/100, delta 700 <= 1000
    run_seq(8'd50, 8'd0, 4'd0);
    step();
    chk("t2_s1", 32'(s1_o), 32'd40800);
    chk("t2_s2", 32'(s2_o), 32'd40100);
    chk("t2_cmp", 32'(bus.cmp_o), 32'd0);
    chk("t2_cnt", 32'(eval_cnt), 32'd2);

    // idac_o=15: thr = 1000+960 = 1960
    run_seq(8'd127, 8'd63, 4'd15);
    step();
    chk("t3_cmp_hi", 32'(bus.cmp_o), 32'd1);
    run_seq(8'd120, 8'd0, 4'd15);
    step();
    chk("t3_s1", 32'(s1_o), 32'd41920);
    chk("t3_s2", 32'(s2_o), 32'd40240);
    chk("t3_cmp_lo", 32'(bus.cmp_o), 32'd0);
    chk("t3_cnt", 32'(eval_cnt), 32'd4);

    // Collision: no capture, no evaluation, sticky error.
    bus.ib = 8'd127; bus.ibf = 8'd63; bus.idac_o = 4'd0; bus.diode = 8'h01;
    bus.c1 = 2'd2; bus.c2 = 2'd2;
    step();
    bus.c1 = 2'd0; bus.c2 = 2'd0;
    step(); step();
    chk("t4_perr", 32'(proto_err), 32'd1);
    chk("t4_s1", 32'(s1_o), 32'd41920);
    chk("t4_s2", 32'(s2_o), 32'd40240);
    chk("t4_cnt", 32'(eval_cnt), 32'd4);
    step(); step(); step();
    chk("t4_perr_sticky", 32'(proto_err), 32'd1);
    pulse_reset();
    chk("t4_perr_clr", 32'(proto_err), 32'd0);
    chk("t4_cnt_clr", 32'(eval_cnt), 32'd0);
    chk("t4_s1_clr", 32'(s1_o), 32'd40000);

    // Illegal phase code on c2.
    bus.c2 = 2'd3;
    step();
    bus.c2 = 2'd0;
    step();
    chk("t5_illegal", 32'(proto_err), 32'd1);
    pulse_reset();

    // res_n low blocks s1 capture.
    bus.res_n = 1'b0; bus.diode = 8'h01; bus.c1 = 2'd2;
    step();
    bus.c1 = 2'd0; bus.res_n = 1'b1;
    step();
    chk("t6_s1_hold", 32'(s1_o), 32'd40000);

    // Open stack on s2: saturated sample, delta negative, cmp drops from 1 to 0.
    run_seq(8'd127, 8'd63, 4'd0);
    step();
    chk("t7_cmp_pre", 32'(bus.cmp_o), 32'd1);
    bus.diode = 8'h00; bus.c2 = 2'd2;
    step();
    bus.c2 = 2'd0;
    step(); step();
    chk("t7_s2_sat", 32'(s2_o), 32'hFFFFF);
    chk("t7_cmp", 32'(bus.cmp_o), 32'd0);
    chk("t7_cnt", 32'(eval_cnt), 32'd2);

    // Back-to-back s2 captures: one evaluation, newest sample wins.
    bus.diode = 8'h00; bus.c2 = 2'd2;
    step();
    bus.diode = 8'hFF;
    step();
    chk("t8_no_eval", 32'(eval_cnt), 32'd2);
    bus.c2 = 2'd0;
    step(); step(); step(); step();
    chk("t8_s2", 32'(s2_o), 32'd40285);
    chk("t8_cmp", 32'(bus.cmp_o), 32'd1);
    chk("t8_cnt", 32'(eval_cnt), 32'd3);

    // Shift boundaries: 2 diodes -> >>1, 3 diodes -> >>2.
    bus.diode = 8'h03; bus.c1 = 2'd2;
    step();
    bus.diode = 8'h07; bus.c1 = 2'd0; bus.c2 = 2'd2;
    step();
    bus.c2 = 2'd0;
    step(); step();
    chk("t9_s1_n2", 32'(s1_o), 32'd41142);
    chk("t9_s2_n3", 32'(s2_o), 32'd40571);
    chk("t9_cmp", 32'(bus.cmp_o), 32'd0);
    chk("t9_cnt", 32'(eval_cnt), 32'd4);

    // Reset on the evaluation edge drops the pending evaluation.
    bus.diode = 8'h01; bus.c1 = 2'd2;
    step();
    bus.diode = 8'hFF; bus.c1 = 2'd0; bus.c2 = 2'd2;
    step();
    bus.c2 = 2'd0; reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step(); step();
    chk("t10_cnt", 32'(eval_cnt), 32'd0);
    chk("t10_cmp", 32'(bus.cmp_o), 32'd0);
    chk("t10_s2", 32'(s2_o), 32'd40000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
